// File: rtl/regfile_sb_pkg.sv
// Shared constants and state encoding for the
// quantr-i integer register file.
package regfile_sb_pkg;

  localparam logic RESET = 1'b0;
  localparam logic [63:0] ZeroDWord = 64'h0;

  typedef enum logic {
    REGFILE_INIT = 1'b0,
    REGFILE_RUN  = 1'b1
  } regfile_state_e;

endpackage

// File: rtl/regfile_sb_bypass.sv
// One read port's address match and priority mux
// across all write ports; highest index wins.
module regfile_bypass #(
  parameter int XLEN = 64,
  parameter int NWR  = 2,
  parameter int AW   = 5
) (
  input  logic [NWR-1:0]      wr_en,
  input  logic [NWR*AW-1:0]   wr_addr,
  input  logic [NWR*XLEN-1:0] wr_data,
  input  logic [AW-1:0]       rd_addr,
  output logic                hit,
  output logic [XLEN-1:0]     data
);

  always_comb begin
    hit  = 1'b0;
    data = '0;
    for (int w = 0; w < NWR; w++) begin
      if (wr_en[w] &&
          wr_addr[w*AW +: AW] == rd_addr) begin
        hit  = 1'b1;
        data = wr_data[w*XLEN +: XLEN];
      end
    end
  end

endmodule

// File: rtl/regfile_sb.sv
// Parametrised register file with pending-write
// scoreboard and post-reset clear sequencer.
module regfile_sb
  import regfile_sb_pkg::*;
#(
  parameter int XLEN = 64,
  parameter int NREG = 32,
  parameter int NRD  = 2,
  parameter int NWR  = 2,
  localparam int AW  = $clog2(NREG)
) (
  input  logic                clk,
  input  logic                rst,
  output logic                ready,
  input  logic [NWR-1:0]      wr_en,
  input  logic [NWR*AW-1:0]   wr_addr,
  input  logic [NWR*XLEN-1:0] wr_data,
  input  logic [NRD-1:0]      rd_en,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_busy,
  input  logic                iss_en,
  input  logic [AW-1:0]       iss_addr
);

  regfile_state_e  state;
  regfile_state_e  state_nx;
  logic [AW-1:0]   clr_idx;
  logic [XLEN-1:0] regs [NREG];
  logic [NREG-1:0] pend;
  logic [NREG-1:0] pend_nx;
  logic            run;
  logic [NRD-1:0]  hit;
  logic [NRD*XLEN-1:0] byp;

  assign run   = (state == REGFILE_RUN);
  assign ready = run;

  always_ff @(posedge clk) begin
    if (rst == RESET) state <= REGFILE_INIT;
    else              state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (1'b1)
      (state == REGFILE_INIT): begin
        if (clr_idx == AW'(NREG - 1))
          state_nx = REGFILE_RUN;
      end
      default: state_nx = state;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst == RESET)
      clr_idx <= '0;
    else if (!run)
      clr_idx <= clr_idx + 1'b1;
  end

  // Storage carries no reset; INIT zeroes one entry per cycle.
  always_ff @(posedge clk) begin
    if (rst != RESET) begin
      if (!run) begin
        regs[clr_idx] <= XLEN'(ZeroDWord);
      end else begin
        for (int w = 0; w < NWR; w++) begin
          if (wr_en[w] && wr_addr[w*AW +: AW] != '0)
            regs[wr_addr[w*AW +: AW]] <=
              wr_data[w*XLEN +: XLEN];
        end
      end
    end
  end

  // Issue applied after writeback clears so the newer producer wins.
  always_comb begin
    pend_nx = pend;
    if (run) begin
      for (int w = 0; w < NWR; w++) begin
        if (wr_en[w])
          pend_nx[wr_addr[w*AW +: AW]] = 1'b0;
      end
      if (iss_en)
        pend_nx[iss_addr] = 1'b1;
    end
    pend_nx[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst == RESET) pend <= '0;
    else              pend <= pend_nx;
  end

  for (genvar p = 0; p < NRD; p++) begin : g_byp
    regfile_bypass #(
      .XLEN (XLEN),
      .NWR  (NWR),
      .AW   (AW)
    ) u_byp (
      .wr_en   (wr_en),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .rd_addr (rd_addr[p*AW +: AW]),
      .hit     (hit[p]),
      .data    (byp[p*XLEN +: XLEN])
    );
  end

  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    for (int p = 0; p < NRD; p++) begin
      if (run && rd_en[p] &&
          rd_addr[p*AW +: AW] != '0) begin
        rd_data[p*XLEN +: XLEN] = hit[p] ?
          byp[p*XLEN +: XLEN] :
          regs[rd_addr[p*AW +: AW]];
        rd_busy[p] = pend[rd_addr[p*AW +: AW]] &
                     ~hit[p];
      end
    end
  end

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised integer register file for the quantr-i core. It supersedes the fixed two-read/one-write file with configurable read/write port counts and a per-register scoreboard of pending writes. It also has a post-reset clear sequencer, so the architectural state is zeroed without a reset fan-out to every storage bit. It sits between decode/issue (read and issue ports) and writeback (write ports).

## Interface
- XLEN, 64, data width in bits
- NREG, 32, number of registers; register 0 hard-wired to zero
- NRD, 2, number of read ports
- NWR, 2, number of write ports
- AW, $clog2(NREG), address width (derived, not overridden)

- clk  in  1  core clock; single clock domain
- rst  in  1  reset, synchronous, active-low
- ready  out  1  high once the clear sequence is done; reset value 0
- wr_en  in  NWR  per-port write enable
- wr_addr  in  NWR*AW  packed write addresses, port 0 in LSBs
- wr_data  in  NWR*XLEN  packed write data
- rd_en  in  NRD  per-port read enable
- rd_addr  in  NRD*AW  packed read addresses
- rd_data  out  NRD*XLEN  packed read data; combinational; 0 during reset/INIT
- rd_busy  out  NRD  read register has an outstanding producer; 0 during reset/INIT
- iss_en  in  1  mark destination pending (instruction issued)
- iss_addr  in  AW  destination being marked

## Operation
- States: INIT, RUN.
- rst==0 at an edge: state←INIT, clr_idx←0, all pending bits←0, ready←0.
- INIT: each cycle regs[clr_idx]←0 and clr_idx++. When clr_idx==NREG-1, go to RUN; ready=1 from the next cycle.
- In INIT, wr_en and iss_en are ignored.
- Write (RUN): for each port with wr_en=1 and wr_addr≠0, regs[wr_addr]←wr_data at the edge.
- Write conflict: several ports writing the same address → the highest-index port wins.
- Read, per port p:
  - rd_data=0 if not RUN, rd_en[p]=0, or rd_addr[p]=0.
  - Otherwise, bypass: wr_data of the highest-index port with wr_en=1 and wr_addr==rd_addr[p].
  - Otherwise regs[rd_addr[p]].
- Scoreboard pending[NREG]:
  - iss_en=1 and iss_addr≠0 sets pending[iss_addr].
  - Any write port with wr_en=1 clears pending[wr_addr].
  - Set and clear of the same address in one cycle → set wins (the newer producer is outstanding).
  - pending[0] is constantly 0.
- rd_busy[p] = RUN & rd_en[p] & (rd_addr[p]≠0) & pending[rd_addr[p]] & ~bypass_hit[p].
- Reset mid-operation (RUN or INIT) restarts INIT from index 0. Stored contents are overwritten progressively, not instantly.

## Timing
- Read: 0-cycle combinational, including bypass.
- Write visible through the array: the cycle after the write edge. Visible through bypass in the same cycle.
- Issue: pending is set the cycle after iss_en.
- ready: rises exactly NREG cycles after the first edge with rst==1.
- No handshake on ports. Callers must hold off issue/writeback until ready=1; requests before that are dropped.

## Structure
- Shared defines header gets:
  - `RESET` (active level 1'b0)
  - `ZeroDWord`
  - state encodings REGFILE_INIT / REGFILE_RUN
- One sub-module, regfile_bypass: a single read port's address-match and priority mux across NWR write ports, instantiated NRD times.
- Storage array, clear sequencer and scoreboard stay in the top module.

## Test plan
- Reset release, NREG=32: ready=0 for 32 cycles, then 1. Writes issued meanwhile are dropped; all 31 registers then read 0.
- RUN, write x5←0xDEAD_BEEF on port 0 with a read of x5 on port 1 in the same cycle: rd_data=0xDEAD_BEEF (bypass). The next cycle, with no write, it still reads 0xDEAD_BEEF.
- Ports 0 and 1 both write x7 (0x1111, 0x2222) in one cycle: same-cycle read gives 0x2222; next-cycle read gives 0x2222. A write to x0 of 0xFFFF reads back 0.
- iss_en x9 at cycle t: rd_busy=1 for x9 from t+1. Writeback to x9 at t+3: rd_busy=0 in t+3 (bypass) and after. iss_en and writeback of x9 in the same cycle: rd_busy stays 1.
- rd_en=0 with x3 holding 0x42: rd_data=0 and rd_busy=0.
- Assert rst=0 for one cycle mid-run with x4=0x55 and x4 pending: the next cycle ready=0 and rd_busy=0. After 32 cycles ready=1 and x4 reads 0.
